formula_2_credit_out_buf: RTL

Credit-based output buffer placed directly downstream of the three-isqrt formula pipeline. The pipeline has a fixed latency and no stall input, so this block gates how many argument sets may enter it. It admits a new argument set only when FIFO space is guaranteed for the result. It captures every `res_vld`/`res` beat into a flip-flop FIFO and re-presents the results on a valid/ready stream to a consumer that may apply backpressure.

---
 rtl/formula_2_credit_out_buf.sv | 116 +++++++++++
 1 files changed

// File: rtl/formula_2_credit_out_buf.sv
// formula_2_credit_out_buf
// Credit-gated output buffer behind the fixed-latency formula pipeline.
// An argument set is launched only when the FIFO is guaranteed to have room
// for its result. Every returned result is captured into a flip-flop FIFO and
// replayed on a valid/ready stream.
// Optional build macro: FORMULA_CREDIT_OVF_CHECK_EN enables the sticky ovf
// error flag and protection against a full-FIFO push. Without it, ovf is
// tied low.
module formula_2_credit_out_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  output logic             pipe_arg_vld,
  input  logic             res_vld,
  input  logic [WIDTH-1:0] res,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW:0]   LIMIT_C = (CW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW:0] occupancy;
  logic        launch;
  logic        pop;
  logic        push_en;
  logic        ret_en;

  // Credits come from registered state only; reset forces them off
  assign occupancy    = {1'b0, count} + {1'b0, inflight};
  assign up_rdy       = !rst && (occupancy < LIMIT_C);
  assign launch       = up_vld && up_rdy;
  assign pipe_arg_vld = launch;
  assign out_vld      = (count != '0);
  assign pop          = out_vld && out_rdy;
  assign out_data     = mem[rd_ptr];

`ifdef FORMULA_CREDIT_OVF_CHECK_EN
  // A push into a full FIFO with no pop is dropped so the pointers never
  // cross; a result without a credit must not underflow inflight.
  assign push_en = res_vld && !((count == FULL_C) && !pop);
  assign ret_en  = res_vld && (inflight != '0);

  // Sticky error flag for protocol violations by the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (res_vld && (((count == FULL_C) && !pop) || (inflight == '0))) begin
      ovf <= 1'b1;
    end
  end
`else
  assign push_en = res_vld;
  assign ret_en  = res_vld;
  assign ovf     = 1'b0;
`endif

  // Result storage; data path carries no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= res;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO occupancy: net of push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outstanding credits: net of launch and returned result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({launch, ret_en})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
